// File: rtl/mem_bank_array.sv
// Multi-port SRAM bank array: per-row round-robin arbitration, wide words split over
// column macros, fixed-latency in-order responses and out-of-range error reporting.
module mem_bank_array #(
  parameter int NumPorts      = 2,
  parameter int AddrWidth     = 20,
  parameter int WordWidth     = 512,
  parameter int SramDataWidth = 256,
  parameter int SramNumWords  = 512,
  parameter int NumBankRows   = 8,
  parameter int SramLatency   = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumPorts-1:0]             req_i,
  output logic [NumPorts-1:0]             gnt_o,
  input  logic [NumPorts*AddrWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0]             we_i,
  input  logic [NumPorts*WordWidth-1:0]   wdata_i,
  input  logic [NumPorts*WordWidth/8-1:0] be_i,
  output logic [NumPorts-1:0]             rvalid_o,
  output logic [NumPorts*WordWidth-1:0]   rdata_o,
  output logic [NumPorts-1:0]             err_o
);
  localparam int NumBanksPerWord = WordWidth / SramDataWidth;
  localparam int ByteOff   = $clog2(WordWidth / 8);
  localparam int WordBits  = $clog2(SramNumWords);
  localparam int RowBits   = $clog2(NumBankRows);
  localparam int RowW      = (RowBits > 0) ? RowBits : 1;
  localparam int PortW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int CapBits   = ByteOff + WordBits + RowBits;
  localparam int SramBytes = SramDataWidth / 8;
  localparam int WordBytes = WordWidth / 8;

  logic [WordBits-1:0] word_idx [NumPorts];
  logic [RowW-1:0]     row_idx  [NumPorts];
  logic [NumPorts-1:0] oor;

  for (genvar p = 0; p < NumPorts; p++) begin : g_dec
    logic [AddrWidth-1:0] a;
    logic                 unused_lo;
    assign a           = addr_i[p*AddrWidth +: AddrWidth];
    assign unused_lo   = ^a[ByteOff-1:0];
    assign word_idx[p] = a[ByteOff +: WordBits];
    if (RowBits > 0) begin : g_row
      assign row_idx[p] = a[ByteOff+WordBits +: RowBits];
    end else begin : g_norow
      assign row_idx[p] = '0;
    end
    if (AddrWidth > CapBits) begin : g_oor
      assign oor[p] = |a[AddrWidth-1:CapBits];
    end else begin : g_nooor
      assign oor[p] = 1'b0;
    end
  end

  // Per-row round-robin; out-of-range requests bypass arbitration entirely.
  logic [PortW-1:0]       rr_q    [NumBankRows];
  logic [PortW-1:0]       row_win [NumBankRows];
  logic [NumBankRows-1:0] row_gnt;
  logic [NumBankRows-1:0] row_act;
  logic [NumPorts-1:0]    arb_gnt;
  logic [NumPorts-1:0]    cand;

  assign cand = req_i & ~oor;

  always_comb begin
    row_gnt = '0;
    arb_gnt = '0;
    for (int r = 0; r < NumBankRows; r++) begin
      row_win[r] = '0;
      for (int k = 0; k < NumPorts; k++) begin
        int idx;
        idx = int'(rr_q[r]) + k;
        if (idx >= NumPorts) idx = idx - NumPorts;
        if (!row_gnt[r] && cand[idx] && row_idx[idx] == RowW'(r)) begin
          row_gnt[r]   = 1'b1;
          row_win[r]   = PortW'(idx);
          arb_gnt[idx] = 1'b1;
        end
      end
    end
  end

  assign gnt_o   = rst_i ? '0 : ((req_i & oor) | arb_gnt);
  assign row_act = row_gnt & {NumBankRows{~rst_i}};

  always_ff @(posedge clk_i) begin
    for (int r = 0; r < NumBankRows; r++) begin
      if (rst_i) rr_q[r] <= '0;
      else if (row_gnt[r])
        rr_q[r] <= (int'(row_win[r]) == NumPorts - 1) ? '0 : row_win[r] + 1'b1;
    end
  end

  logic [WordBits-1:0]    m_addr  [NumBankRows];
  logic [WordWidth-1:0]   m_wdata [NumBankRows];
  logic [WordBytes-1:0]   m_be    [NumBankRows];
  logic [NumBankRows-1:0] m_we;

  always_comb begin
    m_we = '0;
    for (int r = 0; r < NumBankRows; r++) begin
      m_addr[r]  = '0;
      m_wdata[r] = '0;
      m_be[r]    = '0;
      for (int p = 0; p < NumPorts; p++) begin
        if (row_win[r] == PortW'(p)) begin
          m_addr[r]  = word_idx[p];
          m_wdata[r] = wdata_i[p*WordWidth +: WordWidth];
          m_be[r]    = be_i[p*WordBytes +: WordBytes];
          m_we[r]    = we_i[p];
        end
      end
    end
  end

  logic [WordWidth-1:0] row_rdata [NumBankRows];

  for (genvar r = 0; r < NumBankRows; r++) begin : g_mrow
    logic [WordWidth-1:0] q_p0;
    for (genvar b = 0; b < NumBanksPerWord; b++) begin : g_bank
      logic [SramDataWidth-1:0] mem [SramNumWords];
      logic [SramDataWidth-1:0] bank_q;
      // Stage p0: macro array access at the grant edge
      always_ff @(posedge clk_i) begin
        if (row_act[r] && m_we[r]) begin
          for (int y = 0; y < SramBytes; y++)
            if (m_be[r][b*SramBytes + y])
              mem[m_addr[r]][y*8 +: 8] <= m_wdata[r][(b*SramBytes + y)*8 +: 8];
        end
        if (row_act[r] && !m_we[r]) bank_q <= mem[m_addr[r]];
      end
      assign q_p0[b*SramDataWidth +: SramDataWidth] = bank_q;
    end
    if (SramLatency > 1) begin : g_dly
      logic [WordWidth-1:0] dly_p [SramLatency-1];
      // Stages p1..: remaining macro read latency
      always_ff @(posedge clk_i) begin
        dly_p[0] <= q_p0;
        for (int s = 1; s < SramLatency - 1; s++) dly_p[s] <= dly_p[s-1];
      end
      assign row_rdata[r] = dly_p[SramLatency-2];
    end else begin : g_nodly
      assign row_rdata[r] = q_p0;
    end
  end

  logic [SramLatency-1:0] trk_vld [NumPorts];
  logic [SramLatency-1:0] trk_we  [NumPorts];
  logic [SramLatency-1:0] trk_oor [NumPorts];
  logic [RowW-1:0]        trk_row [NumPorts][SramLatency];

  // Response tracking: valid is control (reset), row/we/oor are data (not reset)
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      if (rst_i) trk_vld[p] <= '0;
      else       trk_vld[p] <= (trk_vld[p] << 1) | SramLatency'(gnt_o[p]);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      trk_we[p]  <= (trk_we[p]  << 1) | SramLatency'(we_i[p]);
      trk_oor[p] <= (trk_oor[p] << 1) | SramLatency'(oor[p]);
      for (int s = SramLatency - 1; s > 0; s--) trk_row[p][s] <= trk_row[p][s-1];
      trk_row[p][0] <= row_idx[p];
    end
  end

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    err_o    = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (!rst_i && trk_vld[p][SramLatency-1]) begin
        rvalid_o[p] = 1'b1;
        err_o[p]    = trk_oor[p][SramLatency-1];
        if (!trk_we[p][SramLatency-1] && !trk_oor[p][SramLatency-1]) begin
          for (int r = 0; r < NumBankRows; r++)
            if (trk_row[p][SramLatency-1] == RowW'(r))
              rdata_o[p*WordWidth +: WordWidth] = row_rdata[r];
        end
      end
    end
  end

endmodule

// File: doc/mem_bank_array.md
Name: mem_bank_array

Overview:
- Multi-port, parametrised SRAM bank array for memory tiles, driven directly by one or more mem-side request ports (e.g. axi_to_mem outputs).
- Each port accesses a full wide word spread over NumBanksPerWord column macros. The address selects one of NumBankRows macro rows.
- Adds per-row round-robin arbitration with real grants, a configurable SRAM read latency with a matching response pipeline, and out-of-range error signalling.

Parameters:
- NumPorts, 2: number of independent request ports.
- AddrWidth, 20: byte-address width per port.
- WordWidth, 512: port data width in bits.
- SramDataWidth, 256: macro data width; WordWidth must be an integer multiple of it.
- SramNumWords, 512: words per macro; must be a power of 2.
- NumBankRows, 8: macro rows; must be a power of 2.
- SramLatency, 1: macro read latency in cycles; must be at least 1.
- Derived values:
  - NumBanksPerWord = WordWidth/SramDataWidth.
  - ByteOff = clog2(WordWidth/8).
  - Capacity = NumBankRows*SramNumWords*WordWidth/8 bytes.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  NumPorts  request valid per port.
- gnt_o  out  NumPorts  request accepted this cycle.
- addr_i  in  NumPorts*AddrWidth  byte address, word aligned.
- we_i  in  NumPorts  1 = write.
- wdata_i  in  NumPorts*WordWidth  write data.
- be_i  in  NumPorts*WordWidth/8  byte enables.
- rvalid_o  out  NumPorts  response valid.
- rdata_o  out  NumPorts*WordWidth  read data.
- err_o  out  NumPorts  response error, qualified by rvalid_o.

Behaviour:
- Address decode, per port:
  - word index = addr[ByteOff +: clog2(SramNumWords)].
  - row = next clog2(NumBankRows) bits.
  - Bits at or above clog2(Capacity) nonzero means out-of-range (OOR).
  - addr[ByteOff-1:0] is ignored.
- Column split: WordWidth is split LSB-first into NumBanksPerWord slices. All macros of the selected row are accessed together; be_i is sliced the same way.
- Arbitration is combinational, per row:
  - All ports requesting the same row compete. One winner is chosen round-robin starting at that row's pointer rr[row].
  - Ports targeting different rows are granted in the same cycle.
  - gnt_o is combinational from req_i/addr_i, with no dependency on a grant in the same cycle.
  - On a grant in a row: rr[row] <= winner+1 mod NumPorts. A row with no grant keeps its pointer.
- OOR requests are always granted immediately, access no macro and take no part in arbitration.
- A loser keeps req_i high with stable fields until granted (protocol rule; assertion in bench).
- Macro access:
  - Winning port drives req/we/addr/wdata/be to every macro in its row.
  - A macro write takes effect at the clock edge of the grant.
- Responses:
  - Every granted request (read, write or OOR) yields exactly one rvalid_o pulse on its port, exactly SramLatency cycles after the grant cycle.
  - Responses are in order per port; there is no backpressure.
  - A response-tracking shift register of depth SramLatency per port carries {valid, row, we, oor}. rdata_o is muxed from the tracked row's macros.
  - For writes and OOR, rdata_o = 0. For OOR, err_o = 1; otherwise err_o = 0.
  - When rvalid_o is low, rdata_o is 0 and err_o is 0.
- Read/write ordering:
  - A read granted the cycle after a write to the same address returns the new data.
  - A same-cycle read and write to the same row are serialised by arbitration; the winner's access is seen first.
- Reset:
  - All outputs 0 while rst_i is high.
  - rr pointers and the tracking pipeline are cleared; in-flight responses are dropped, with no rvalid after reset.
  - Macro contents are undefined across reset.
  - gnt_o is forced to 0 while rst_i is high.

Test Plan:
- Single port, NumPorts=2, SramLatency=1:
  - Write 0xA5-pattern to 0x08040 (row 1, word 1), then read it.
  - Expected: gnt the same cycle; read rvalid 1 cycle later with rdata = pattern, err = 0; write rvalid with rdata = 0.
- Conflict:
  - Both ports read row 3 for 4 consecutive cycles with reset pointers.
  - Expected: grants alternate P0, P1, P0, P1; each rvalid follows its own grant by exactly 1 cycle; no lost or duplicated responses.
- No conflict:
  - P0 targets 0x00000 (row 0) and P1 targets 0x38000 (row 7) in the same cycle.
  - Expected: both gnt = 1 and both rvalid in the next cycle.
- OOR:
  - P0 reads 0xC0000.
  - Expected: gnt the same cycle; rvalid after SramLatency with err = 1, rdata = 0; no macro req is asserted.
- Latency and byte enables, SramLatency=3, back-to-back:
  - Write be = low 32 bytes only, then read the same address, then read another row.
  - Expected: responses exactly 3 cycles after each grant, in order; only the low half of the word is updated.
- Reset mid-operation:
  - Assert rst_i one cycle after 2 reads are granted (SramLatency=2).
  - Expected: no rvalid for those reads; after release, rr = 0 (P0 wins the first conflict).
